// File: rtl/wbck_arbiter_if.sv
// Write-back request/issue/register-file bundle between execution units and the arbiter.
// The slave modport is the arbiter side; master is the requester/issue/register-file side.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef RFIDX_WIDTH
`define RFIDX_WIDTH 5
`endif
`ifndef RFREG_NUM
`define RFREG_NUM 32
`endif

interface wbck_arbiter_if;
    logic [2:0]                  req_valid;
    logic [3*`RFIDX_WIDTH-1:0]   req_idx;
    logic [3*`XLEN-1:0]          req_dat;
    logic [2:0]                  req_ready;
    logic                        iss_valid;
    logic [`RFIDX_WIDTH-1:0]     iss_idx;
    logic                        wbck_dest_wen;
    logic [`RFIDX_WIDTH-1:0]     wbck_dest_idx;
    logic [`XLEN-1:0]            wbck_dest_dat;
    logic [`RFREG_NUM-1:0]       busy_vec;

    modport slave (
        input  req_valid, req_idx, req_dat, iss_valid, iss_idx,
        output req_ready, wbck_dest_wen, wbck_dest_idx, wbck_dest_dat, busy_vec
    );

    modport master (
        output req_valid, req_idx, req_dat, iss_valid, iss_idx,
        input  req_ready, wbck_dest_wen, wbck_dest_idx, wbck_dest_dat, busy_vec
    );
endinterface

// File: rtl/wbck_arbiter.sv
// Purpose: 3-way write-back arbiter (ALU/LSU/CSR) with destination busy scoreboard; WBCK_RR_EN selects round-robin.
// Latency: grant combinational, register-file write registered one cycle after the transfer.
// Backpressure: losers see req_ready=0 and hold their request; one transfer accepted per cycle.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef RFIDX_WIDTH
`define RFIDX_WIDTH 5
`endif
`ifndef RFREG_NUM
`define RFREG_NUM 32
`endif

module wbck_arbiter (
    input  logic          clk,
    input  logic          rst,
    wbck_arbiter_if.slave wb
);
    localparam int IW = `RFIDX_WIDTH;
    localparam int DW = `XLEN;

    logic [2:0]              grant;
    logic [2:0]              ready;
    logic                    xfer;
    logic [IW-1:0]           win_idx;
    logic [DW-1:0]           win_dat;
    logic                    wen_q;
    logic [IW-1:0]           idx_q;
    logic [DW-1:0]           dat_q;
    logic [`RFREG_NUM-1:0]   busy_q;
    logic [`RFREG_NUM-1:0]   busy_nxt;

`ifdef WBCK_RR_EN
    logic [1:0] rr_ptr;
    logic [1:0] rr_nxt;
    logic [2:0] pos;

    // Search p, p+1, p+2 (mod 3); first valid requester wins.
    always_comb begin
        grant = '0;
        pos   = '0;
        for (int i = 0; i < 3; i++) begin
            pos = {1'b0, rr_ptr} + 3'(i);
            if (pos >= 3'd3) pos = pos - 3'd3;
            if (grant == 3'b000 && wb.req_valid[pos[1:0]]) grant[pos[1:0]] = 1'b1;
        end
    end

    always_comb begin
        rr_nxt = rr_ptr;
        if (ready[0])      rr_nxt = 2'd1;
        else if (ready[1]) rr_nxt = 2'd2;
        else if (ready[2]) rr_nxt = 2'd0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rr_ptr <= 2'd0;
        else      rr_ptr <= rr_nxt;
    end
`else
    // Fixed priority: LSU > ALU > CSR.
    always_comb begin
        grant    = '0;
        grant[1] = wb.req_valid[1];
        grant[0] = wb.req_valid[0] & ~wb.req_valid[1];
        grant[2] = wb.req_valid[2] & ~wb.req_valid[1] & ~wb.req_valid[0];
    end
`endif

    assign ready        = grant & {3{rst}};
    assign xfer         = |ready;
    assign wb.req_ready = ready;

    always_comb begin
        win_idx = '0;
        win_dat = '0;
        for (int k = 0; k < 3; k++) begin
            if (ready[k]) begin
                win_idx = wb.req_idx[k*IW +: IW];
                win_dat = wb.req_dat[k*DW +: DW];
            end
        end
    end

    // Issue set is applied after the write-back clear so a same-index collision stays busy.
    always_comb begin
        busy_nxt = busy_q;
        if (xfer) busy_nxt[win_idx] = 1'b0;
        if (wb.iss_valid && wb.iss_idx != '0) busy_nxt[wb.iss_idx] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wen_q  <= 1'b0;
            idx_q  <= '0;
            dat_q  <= '0;
            busy_q <= '0;
        end else begin
            wen_q  <= xfer && (win_idx != '0);
            busy_q <= busy_nxt;
            if (xfer) begin
                idx_q <= win_idx;
                dat_q <= win_dat;
            end
        end
    end

    assign wb.wbck_dest_wen = wen_q;
    assign wb.wbck_dest_idx = idx_q;
    assign wb.wbck_dest_dat = dat_q;
    assign wb.busy_vec      = busy_q;
endmodule

// File: tb/tb_wbck_arbiter.sv
// Directed bench for wbck_arbiter: grant order, write-back latency, scoreboard set/clear and reset behaviour.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef RFIDX_WIDTH
`define RFIDX_WIDTH 5
`endif
`ifndef RFREG_NUM
`define RFREG_NUM 32
`endif

module tb_wbck_arbiter;
    localparam int IW = `RFIDX_WIDTH;
    localparam int DW = `XLEN;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    wbck_arbiter_if wb_if ();

    wbck_arbiter dut (
        .clk (clk),
        .rst (rst),
        .wb  (wb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [IW-1:0] idx, input logic [DW-1:0] dat);
        wb_if.req_idx[k*IW +: IW] = idx;
        wb_if.req_dat[k*DW +: DW] = dat;
    endtask

    logic [2:0]    exp_g   [3];
    logic [IW-1:0] exp_idx [3];
    logic [DW-1:0] exp_dat [3];

    initial begin
        n_cmp = 0;
        n_err = 0;
`ifdef WBCK_RR_EN
        exp_g[0] = 3'b001; exp_idx[0] = 1; exp_dat[0] = 'hA1;
        exp_g[1] = 3'b010; exp_idx[1] = 2; exp_dat[1] = 'hB2;
        exp_g[2] = 3'b100; exp_idx[2] = 3; exp_dat[2] = 'hC3;
`else
        for (int i = 0; i < 3; i++) begin
            exp_g[i] = 3'b010; exp_idx[i] = 2; exp_dat[i] = 'hB2;
        end
`endif
        // Reset with all requesters valid: everything must read zero.
        rst             = 1'b0;
        wb_if.req_valid = 3'b111;
        wb_if.req_idx   = '0;
        wb_if.req_dat   = '0;
        wb_if.iss_valid = 1'b0;
        wb_if.iss_idx   = '0;
        set_req(0, 5'd4, 'h11);
        set_req(1, 5'd6, 'h22);
        set_req(2, 5'd8, 'h33);
        #2;
        chk_eq("rst_ready", 64'(wb_if.req_ready), 64'h0);
        chk_eq("rst_wen",   64'(wb_if.wbck_dest_wen), 64'h0);
        chk_eq("rst_idx",   64'(wb_if.wbck_dest_idx), 64'h0);
        chk_eq("rst_dat",   64'(wb_if.wbck_dest_dat), 64'h0);
        chk_eq("rst_busy",  64'(wb_if.busy_vec), 64'h0);
        tick();
        tick();
        wb_if.req_valid = 3'b000;
        rst = 1'b1;
        tick();
        chk_eq("idle_wen", 64'(wb_if.wbck_dest_wen), 64'h0);

        // Single ALU request, idx 5.
        wb_if.req_valid = 3'b001;
        set_req(0, 5'd5, 'h1234);
        #2;
        chk_eq("alu_ready", 64'(wb_if.req_ready), 64'b001);
        tick();
        wb_if.req_valid = 3'b000;
        chk_eq("alu_wen", 64'(wb_if.wbck_dest_wen), 64'h1);
        chk_eq("alu_idx", 64'(wb_if.wbck_dest_idx), 64'd5);
        chk_eq("alu_dat", 64'(wb_if.wbck_dest_dat), 64'h1234);
        tick();
        chk_eq("alu_wen_drop", 64'(wb_if.wbck_dest_wen), 64'h0);
        chk_eq("alu_idx_hold", 64'(wb_if.wbck_dest_idx), 64'd5);
        chk_eq("alu_dat_hold", 64'(wb_if.wbck_dest_dat), 64'h1234);

        // CSR to x0 with a simultaneous issue of x0: accepted, no write, no busy.
        wb_if.req_valid = 3'b100;
        set_req(2, 5'd0, 'hDEAD);
        wb_if.iss_valid = 1'b1;
        wb_if.iss_idx   = 5'd0;
        #2;
        chk_eq("x0_ready", 64'(wb_if.req_ready), 64'b100);
        tick();
        wb_if.req_valid = 3'b000;
        wb_if.iss_valid = 1'b0;
        chk_eq("x0_wen",  64'(wb_if.wbck_dest_wen), 64'h0);
        chk_eq("x0_busy", 64'(wb_if.busy_vec), 64'h0);

        // All three valid for three back-to-back cycles.
        set_req(0, 5'd1, 'hA1);
        set_req(1, 5'd2, 'hB2);
        set_req(2, 5'd3, 'hC3);
        wb_if.req_valid = 3'b111;
        for (int c = 0; c < 3; c++) begin
            #2;
            chk_eq($sformatf("all_ready%0d", c), 64'(wb_if.req_ready), 64'(exp_g[c]));
            tick();
            chk_eq($sformatf("all_wen%0d", c), 64'(wb_if.wbck_dest_wen), 64'h1);
            chk_eq($sformatf("all_idx%0d", c), 64'(wb_if.wbck_dest_idx), 64'(exp_idx[c]));
            chk_eq($sformatf("all_dat%0d", c), 64'(wb_if.wbck_dest_dat), 64'(exp_dat[c]));
        end
        wb_if.req_valid = 3'b000;

        // Issue x7, then LSU writes x7 two cycles later.
        wb_if.iss_valid = 1'b1;
        wb_if.iss_idx   = 5'd7;
        tick();
        wb_if.iss_valid = 1'b0;
        chk_eq("b7_set", 64'(wb_if.busy_vec), 64'h80);
        tick();
        chk_eq("b7_hold", 64'(wb_if.busy_vec), 64'h80);
        wb_if.req_valid = 3'b010;
        set_req(1, 5'd7, 'h77);
        #2;
        chk_eq("b7_ready", 64'(wb_if.req_ready), 64'b010);
        tick();
        wb_if.req_valid = 3'b000;
        chk_eq("b7_clr", 64'(wb_if.busy_vec), 64'h0);
        chk_eq("b7_wen", 64'(wb_if.wbck_dest_wen), 64'h1);
        chk_eq("b7_idx", 64'(wb_if.wbck_dest_idx), 64'd7);

        // Issue x9, then re-issue x9 in the same cycle as its write-back.
        wb_if.iss_valid = 1'b1;
        wb_if.iss_idx   = 5'd9;
        tick();
        chk_eq("b9_set", 64'(wb_if.busy_vec), 64'h200);
        wb_if.req_valid = 3'b001;
        set_req(0, 5'd9, 'h99);
        #2;
        chk_eq("b9_ready", 64'(wb_if.req_ready), 64'b001);
        tick();
        wb_if.req_valid = 3'b000;
        wb_if.iss_valid = 1'b0;
        chk_eq("b9_collide", 64'(wb_if.busy_vec), 64'h200);
        chk_eq("b9_wen", 64'(wb_if.wbck_dest_wen), 64'h1);
        chk_eq("b9_dat", 64'(wb_if.wbck_dest_dat), 64'h99);

        // Mid-stream reset with all requesters valid.
        set_req(0, 5'd1, 'hA1);
        set_req(1, 5'd2, 'hB2);
        set_req(2, 5'd3, 'hC3);
        wb_if.req_valid = 3'b111;
        #2;
        chk_eq("pre_ready", 64'(wb_if.req_ready), 64'b010);
        tick();
        chk_eq("pre_wen", 64'(wb_if.wbck_dest_wen), 64'h1);
        #2;
        rst = 1'b0;
        #1;
        chk_eq("mid_ready", 64'(wb_if.req_ready), 64'h0);
        chk_eq("mid_wen",   64'(wb_if.wbck_dest_wen), 64'h0);
        chk_eq("mid_idx",   64'(wb_if.wbck_dest_idx), 64'h0);
        chk_eq("mid_dat",   64'(wb_if.wbck_dest_dat), 64'h0);
        chk_eq("mid_busy",  64'(wb_if.busy_vec), 64'h0);
        wb_if.req_valid = 3'b101;
        rst = 1'b1;
        #2;
        chk_eq("post_ready", 64'(wb_if.req_ready), 64'b001);
        tick();
        wb_if.req_valid = 3'b000;
        chk_eq("post_wen", 64'(wb_if.wbck_dest_wen), 64'h1);
        chk_eq("post_idx", 64'(wb_if.wbck_dest_idx), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/wbck_arbiter.md
WBCK_ARBITER -- requirements
Module: wbck_arbiter

Interface
REQ-001 Parameters SHALL be none; widths SHALL come from defines.v: `XLEN (data), `RFIDX_WIDTH (5), `RFREG_NUM (32).
REQ-002 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  3  write-back requests; bit0=ALU, bit1=LSU, bit2=CSR.
REQ-005 req_idx  input  3*`RFIDX_WIDTH  destination index per requester; slice k belongs to requester k.
REQ-006 req_dat  input  3*`XLEN  write data per requester; slice k belongs to requester k.
REQ-007 req_ready  output  3  one-hot grant; combinational from req_valid and arbitration state.
REQ-008 iss_valid  input  1  issue stage marks a destination pending.
REQ-009 iss_idx  input  `RFIDX_WIDTH  destination being issued.
REQ-010 wbck_dest_wen  output  1  register-file write enable, registered.
REQ-011 wbck_dest_idx  output  `RFIDX_WIDTH  register-file write index, registered.
REQ-012 wbck_dest_dat  output  `XLEN  register-file write data, registered.
REQ-013 busy_vec  output  `RFREG_NUM  scoreboard; bit i=1 means x[i] has a write outstanding.

Function
REQ-014 req_ready SHALL have at most one bit set and SHALL be zero when req_valid is zero.
REQ-015 A transfer SHALL occur for requester k when req_valid[k] and req_ready[k] are both 1 in the same cycle.
REQ-016 A requester SHALL hold valid, idx and dat stable until its transfer; withdrawal before the transfer is illegal and SHALL NOT be checked.
REQ-017 The cycle after a transfer, wbck_dest_wen SHALL be 1 and wbck_dest_idx/dat SHALL equal the winner's slices (latency 1).
REQ-018 On any cycle without a transfer, wbck_dest_wen SHALL be 0 on the next cycle and idx/dat SHALL hold their last values.
REQ-019 A transfer with idx 0 SHALL be accepted (ready asserted), but wbck_dest_wen SHALL stay 0.
REQ-020 busy_vec[iss_idx] SHALL be set at the edge closing a cycle with iss_valid=1 and iss_idx!=0.
REQ-021 busy_vec[idx] SHALL be cleared at the edge closing a cycle with a transfer to idx.
REQ-022 When a set and a clear of the same idx occur in one cycle, the set SHALL win.
REQ-023 busy_vec[0] SHALL always be 0.
REQ-024 Throughput SHALL be one transfer per cycle, sustained, with no bubbles.

Reset
REQ-025 While rst=0, the block SHALL asynchronously clear wbck_dest_wen, wbck_dest_idx, wbck_dest_dat, busy_vec and the round-robin pointer.
REQ-026 req_ready SHALL be 0 while rst=0.
REQ-027 A transfer whose edge coincides with reset assertion SHALL be lost: no write and no busy clear.

Configuration
REQ-028 With WBCK_RR_EN defined, arbitration SHALL be round-robin; the 2-bit pointer p (reset 0) names the highest-priority requester.
REQ-029 In round-robin mode, search order SHALL be p, p+1, p+2 (mod 3), and on a transfer by k the pointer SHALL become (k+1) mod 3; without a transfer it SHALL hold.
REQ-030 Without WBCK_RR_EN, priority SHALL be fixed: LSU > ALU > CSR, with no pointer state.

Verification
REQ-031 Reset, then a single ALU request (idx 5, dat 0x1234) -> ready=001 the same cycle; next cycle wen=1, idx=5, dat=0x1234; the cycle after, wen=0.
REQ-032 All three requesters held valid for 3 cycles with WBCK_RR_EN -> grants ALU, LSU, CSR in that order; without the macro -> LSU granted 3 times.
REQ-033 iss_valid with idx 7, then an LSU transfer to idx 7 two cycles later -> busy_vec[7] reads 1, then 0 after the transfer edge.
REQ-034 iss_valid idx 9 in the same cycle as a transfer to idx 9 -> busy_vec[9] stays 1.
REQ-035 CSR request with idx 0 -> ready=100; wen stays 0; busy_vec unchanged.
REQ-036 rst driven low mid-stream with all requesters valid -> outputs 0 immediately; after release, first grant is ALU in both modes (round-robin pointer reset to 0; fixed mode, LSU idle).
